// File: rtl/uart_response_transmitter.sv
// uart_response_transmitter
//
// Formats VT100 response requests from the parser into their reply byte
// sequences and sends them on TxD as 8N1 UART frames, or 8E1 when
// UART_TX_EVEN_PARITY_EN is defined.
//
// Ports:
//   clk        single clock
//   rst        synchronous active-high reset
//   reqValid   request strobe, accepted when reqReady is high
//   reqType    0 = DSR, 1 = CPR, 2 = DA, 3 = raw byte
//   reqByte    payload for raw-byte requests
//   cursorRow  0-based row, latched at accept
//   cursorCol  0-based column, latched at accept
//   reqReady   block is idle and can take a request
//   busy       a reply sequence is in progress
//   TxD        serial output, idles high
//
// Optional feature macro: UART_TX_EVEN_PARITY_EN (even parity bit after the data bits).

module uart_response_transmitter #(
    parameter int ClkFrequency = 100_000_000,
    parameter int Baud         = 115200,
    parameter int CoordWidth   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    input  logic [1:0]            reqType,
    input  logic [7:0]            reqByte,
    input  logic [CoordWidth-1:0] cursorRow,
    input  logic [CoordWidth-1:0] cursorCol,
    output logic                  reqReady,
    output logic                  busy,
    output logic                  TxD
);

    localparam int Div   = ClkFrequency / Baud;
    localparam int CntW  = $clog2(Div);
    localparam int VW    = CoordWidth + 1;
    localparam int StepW = $clog2(VW + 1);
`ifdef UART_TX_EVEN_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif

    if (ClkFrequency / Baud < 16) begin : gBaudTooFast
        $error("uart_response_transmitter: ClkFrequency/Baud must be at least 16");
    end
    if (CoordWidth < 1 || CoordWidth > 9) begin : gBadCoordWidth
        $error("uart_response_transmitter: CoordWidth must be in 1..9");
    end

    typedef enum logic [1:0] {IDLE, LOAD, FRAME, NEXT} state_t;

    state_t                 state_q;
    logic                   txd_q;
    logic                   busy_q;
    logic                   ready_q;
    logic [1:0]             type_q;
    logic [7:0]             raw_q;
    logic [3:0]             byteIdx_q;
    logic [FrameBits-1:0]   shift_q;
    logic [CntW-1:0]        bitCnt_q;
    logic [3:0]             bitIdx_q;

    logic [VW-1:0]          rowBin_q, rowBin_d;
    logic [VW-1:0]          colBin_q, colBin_d;
    logic [11:0]            rowBcd_q, rowBcd_d;
    logic [11:0]            colBcd_q, colBcd_d;
    logic [StepW-1:0]       step_q, step_d;

    logic                   accept;
    logic [3:0]             rowDigits, colDigits, seqLen;
    logic [7:0]             curByte;
    logic [FrameBits-1:0]   frameWord;

    assign accept   = reqValid && ready_q;
    assign reqReady = ready_q;
    assign busy     = busy_q;
    assign TxD      = txd_q;

    // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
    // the next binary bit in from the right.
    function automatic logic [11:0] ddStep(input logic [11:0] bcd, input logic inBit);
        logic [11:0] r;
        r = bcd;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return {r[10:0], inBit};
    endfunction

    // Decimal digits printed for a converted value, without leading zeros.
    function automatic logic [3:0] digitCount(input logic [11:0] bcd);
        if (bcd[11:8] != 4'd0) begin
            return 4'd3;
        end else if (bcd[7:4] != 4'd0) begin
            return 4'd2;
        end
        return 4'd1;
    endfunction

    // ASCII for the BCD digit at position pos (0 = hundreds, 2 = ones).
    function automatic logic [7:0] pickDigit(input logic [11:0] bcd, input logic [3:0] pos);
        case (pos)
            4'd0:    return {4'h3, bcd[11:8]};
            4'd1:    return {4'h3, bcd[7:4]};
            default: return {4'h3, bcd[3:0]};
        endcase
    endfunction

    // Row and column conversions run side by side, VW iterations after accept,
    // finishing long before the first digit byte is loaded.
    always_comb begin
        rowBin_d = rowBin_q;
        colBin_d = colBin_q;
        rowBcd_d = rowBcd_q;
        colBcd_d = colBcd_q;
        step_d   = step_q;
        if (accept) begin
            rowBin_d = {1'b0, cursorRow} + VW'(1);
            colBin_d = {1'b0, cursorCol} + VW'(1);
            rowBcd_d = '0;
            colBcd_d = '0;
            step_d   = StepW'(VW);
        end else if (step_q != '0) begin
            rowBcd_d = ddStep(rowBcd_q, rowBin_q[VW-1]);
            colBcd_d = ddStep(colBcd_q, colBin_q[VW-1]);
            rowBin_d = rowBin_q << 1;
            colBin_d = colBin_q << 1;
            step_d   = step_q - StepW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rowBin_q <= '0;
            colBin_q <= '0;
            rowBcd_q <= '0;
            colBcd_q <= '0;
            step_q   <= '0;
        end else begin
            rowBin_q <= rowBin_d;
            colBin_q <= colBin_d;
            rowBcd_q <= rowBcd_d;
            colBcd_q <= colBcd_d;
            step_q   <= step_d;
        end
    end

    assign rowDigits = digitCount(rowBcd_q);
    assign colDigits = digitCount(colBcd_q);

    // Byte at position byteIdx_q of the reply sequence for the latched request.
    always_comb begin
        curByte = 8'h00;
        case (type_q)
            2'd0: begin
                case (byteIdx_q)
                    4'd0:    curByte = 8'h1B;
                    4'd1:    curByte = 8'h5B;
                    4'd2:    curByte = 8'h30;
                    default: curByte = 8'h6E;
                endcase
            end
            2'd1: begin
                if (byteIdx_q == 4'd0) begin
                    curByte = 8'h1B;
                end else if (byteIdx_q == 4'd1) begin
                    curByte = 8'h5B;
                end else if (byteIdx_q < 4'd2 + rowDigits) begin
                    curByte = pickDigit(rowBcd_q, byteIdx_q + 4'd1 - rowDigits);
                end else if (byteIdx_q == 4'd2 + rowDigits) begin
                    curByte = 8'h3B;
                end else if (byteIdx_q < 4'd3 + rowDigits + colDigits) begin
                    curByte = pickDigit(colBcd_q, byteIdx_q - rowDigits - colDigits);
                end else begin
                    curByte = 8'h52;
                end
            end
            2'd2: begin
                case (byteIdx_q)
                    4'd0:    curByte = 8'h1B;
                    4'd1:    curByte = 8'h5B;
                    4'd2:    curByte = 8'h3F;
                    4'd3:    curByte = 8'h31;
                    4'd4:    curByte = 8'h3B;
                    4'd5:    curByte = 8'h30;
                    default: curByte = 8'h63;
                endcase
            end
            default: curByte = raw_q;
        endcase
    end

    always_comb begin
        case (type_q)
            2'd0:    seqLen = 4'd4;
            2'd1:    seqLen = 4'd4 + rowDigits + colDigits;
            2'd2:    seqLen = 4'd7;
            default: seqLen = 4'd1;
        endcase
    end

    // Frame is shifted out LSB first: start bit, data, optional parity, stop.
`ifdef UART_TX_EVEN_PARITY_EN
    assign frameWord = {1'b1, ^curByte, curByte, 1'b0};
`else
    assign frameWord = {1'b1, curByte, 1'b0};
`endif

    // TxD is registered from shift_q[0], so the line lags the FRAME state by
    // one cycle; this overlap with NEXT gives the two-cycle inter-byte gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            type_q    <= 2'd0;
            raw_q     <= 8'h00;
            byteIdx_q <= 4'd0;
            shift_q   <= '0;
            bitCnt_q  <= '0;
            bitIdx_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (accept) begin
                        type_q    <= reqType;
                        raw_q     <= reqByte;
                        byteIdx_q <= 4'd0;
                        state_q   <= LOAD;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    shift_q  <= frameWord;
                    bitCnt_q <= '0;
                    bitIdx_q <= 4'd0;
                    state_q  <= FRAME;
                end
                FRAME: begin
                    txd_q <= shift_q[0];
                    if (bitCnt_q == CntW'(Div - 1)) begin
                        bitCnt_q <= '0;
                        shift_q  <= shift_q >> 1;
                        if (bitIdx_q == 4'(FrameBits - 1)) begin
                            state_q <= NEXT;
                        end else begin
                            bitIdx_q <= bitIdx_q + 4'd1;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + CntW'(1);
                    end
                end
                NEXT: begin
                    txd_q <= 1'b1;
                    if (byteIdx_q + 4'd1 < seqLen) begin
                        byteIdx_q <= byteIdx_q + 4'd1;
                        state_q   <= LOAD;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_response_transmitter.sv
// Testbench for uart_response_transmitter at D = 16 clocks per bit.
// Honours UART_TX_EVEN_PARITY_EN when it is defined for the build.

module tb_uart_response_transmitter;

    localparam int ClkFreq  = 1_600_000;
    localparam int BaudRate = 100_000;
    localparam int CoordW   = 8;
    localparam int Div      = ClkFreq / BaudRate;
`ifdef UART_TX_EVEN_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              reqValid = 1'b0;
    logic [1:0]        reqType = 2'd0;
    logic [7:0]        reqByte = 8'h00;
    logic [CoordW-1:0] cursorRow = '0;
    logic [CoordW-1:0] cursorCol = '0;
    logic              reqReady;
    logic              busy;
    logic              TxD;

    int   assertCount = 0;
    int   failCount = 0;
    bit   checkEn = 1'b0;
    bit   decBusy = 1'b0;
    bit   lastParity = 1'b0;

    bit         expTx[$];
    logic [7:0] expByteQ[$];
    logic [7:0] rxQ[$];
    logic [7:0] reqBytes[$];

    uart_response_transmitter #(
        .ClkFrequency(ClkFreq),
        .Baud        (BaudRate),
        .CoordWidth  (CoordW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reqValid (reqValid),
        .reqType  (reqType),
        .reqByte  (reqByte),
        .cursorRow(cursorRow),
        .cursorCol(cursorCol),
        .reqReady (reqReady),
        .busy     (busy),
        .TxD      (TxD)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reply bytes derived directly from the request definition.
    function automatic void pushNumber(input int coord);
        int v;
        v = coord + 1;
        if (v >= 100) reqBytes.push_back(8'(8'h30 + v / 100));
        if (v >= 10)  reqBytes.push_back(8'(8'h30 + (v / 10) % 10));
        reqBytes.push_back(8'(8'h30 + v % 10));
    endfunction

    function automatic bit frameBit(input logic [7:0] b, input int bi);
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
`ifdef UART_TX_EVEN_PARITY_EN
        if (bi == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Reference model: on every accept, append the expected TxD level for
    // every following cycle (2 idle-high cycles then the frame, per byte).
    always @(posedge clk) begin : model
        bit acc;
        bit bitv;
        if (rst) begin
            expTx.delete();
        end else begin
            acc = reqValid && (expTx.size() == 0);
            if (expTx.size() != 0) void'(expTx.pop_front());
            if (acc) begin
                reqBytes.delete();
                case (reqType)
                    2'd0: begin
                        reqBytes.push_back(8'h1B); reqBytes.push_back(8'h5B);
                        reqBytes.push_back(8'h30); reqBytes.push_back(8'h6E);
                    end
                    2'd1: begin
                        reqBytes.push_back(8'h1B); reqBytes.push_back(8'h5B);
                        pushNumber(int'(cursorRow));
                        reqBytes.push_back(8'h3B);
                        pushNumber(int'(cursorCol));
                        reqBytes.push_back(8'h52);
                    end
                    2'd2: begin
                        reqBytes.push_back(8'h1B); reqBytes.push_back(8'h5B);
                        reqBytes.push_back(8'h3F); reqBytes.push_back(8'h31);
                        reqBytes.push_back(8'h3B); reqBytes.push_back(8'h30);
                        reqBytes.push_back(8'h63);
                    end
                    default: reqBytes.push_back(reqByte);
                endcase
                foreach (reqBytes[k]) begin
                    expByteQ.push_back(reqBytes[k]);
                    expTx.push_back(1'b1);
                    expTx.push_back(1'b1);
                    for (int bi = 0; bi < FrameBits; bi++) begin
                        bitv = frameBit(reqBytes[k], bi);
                        repeat (Div) expTx.push_back(bitv);
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            if (expTx.size() != 0) begin
                checkOutput("TxD", int'(TxD), int'(expTx[0]));
                checkOutput("busy", int'(busy), 1);
                checkOutput("reqReady", int'(reqReady), 0);
            end else begin
                checkOutput("TxD", int'(TxD), 1);
                checkOutput("busy", int'(busy), 0);
                checkOutput("reqReady", int'(reqReady), 1);
            end
        end
    end

    // Line decoder: samples each bit near its middle and collects bytes.
    initial begin : decoder
        logic [7:0] data;
        bit sawRst;
        forever begin
            @(negedge clk);
            if (checkEn && !rst && TxD == 1'b0) begin
                decBusy = 1'b1;
                sawRst = 1'b0;
                data = 8'h00;
                repeat (7) begin @(negedge clk); if (rst) sawRst = 1'b1; end
                for (int i = 0; i < 8; i++) begin
                    repeat (Div) begin @(negedge clk); if (rst) sawRst = 1'b1; end
                    data[i] = TxD;
                end
`ifdef UART_TX_EVEN_PARITY_EN
                repeat (Div) begin @(negedge clk); if (rst) sawRst = 1'b1; end
                if (!sawRst) begin
                    lastParity = TxD;
                    checkOutput("parityBit", int'(TxD), int'(^data));
                end
`endif
                repeat (Div) begin @(negedge clk); if (rst) sawRst = 1'b1; end
                if (!sawRst) checkOutput("stopBit", int'(TxD), 1);
                rxQ.push_back(data);
                decBusy = 1'b0;
            end
        end
    end

    // Presents one request once the block is ready and measures, in cycles
    // after the accept edge, when TxD first goes low and when reqReady returns.
    task automatic applyStimulus(input logic [1:0] t, input logic [7:0] b, input int row,
                                 input int col, output int readyCycles, output int firstLow);
        int waitCnt;
        waitCnt = 0;
        readyCycles = 0;
        firstLow = -1;
        while (!reqReady && waitCnt < 5000) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!reqReady) begin
            checkOutput("readyBeforeRequest", 0, 1);
            return;
        end
        reqType = t;
        reqByte = b;
        cursorRow = CoordW'(row);
        cursorCol = CoordW'(col);
        reqValid = 1'b1;
        @(negedge clk);
        reqValid = 1'b0;
        while (!reqReady && readyCycles < 5000) begin
            @(negedge clk);
            readyCycles++;
            if (firstLow < 0 && TxD == 1'b0) firstLow = readyCycles;
        end
        if (!reqReady) checkOutput("readyAfterSequence", 0, 1);
    endtask

    task automatic waitDecoderIdle();
        int n;
        n = 0;
        while (decBusy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (decBusy) checkOutput("decoderIdle", 0, 1);
    endtask

    // Compares decoded line bytes with a literal sequence (right-aligned, n bytes).
    task automatic checkRx(input string name, input int n, input logic [71:0] bytes);
        waitDecoderIdle();
        checkOutput({name, "Count"}, rxQ.size(), n);
        for (int i = 0; i < n && i < rxQ.size(); i++) begin
            checkOutput($sformatf("%sByte%0d", name, i), int'(rxQ[i]), int'(bytes[8*(n-1-i) +: 8]));
        end
        rxQ.delete();
    endtask

    initial begin : stimulus
        int rc;
        int fl;
        int edges;
        int n;
        logic prevTx;

        // Reset state.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkEn = 1'b1;
        checkOutput("resetTxD", int'(TxD), 1);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetReady", int'(reqReady), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // DSR with edge-accurate timing.
        applyStimulus(2'd0, 8'h00, 0, 0, rc, fl);
        checkOutput("dsrStartBitCycle", fl, 2);
`ifdef UART_TX_EVEN_PARITY_EN
        checkOutput("dsrReadyCycle", rc, 712);
`else
        checkOutput("dsrReadyCycle", rc, 648);
`endif
        checkRx("dsr", 4, 72'h1B5B306E);

        // Cursor position reports.
        applyStimulus(2'd1, 8'h00, 23, 79, rc, fl);
        checkRx("cpr23x79", 8, 72'h1B5B32343B383052);
        applyStimulus(2'd1, 8'h00, 0, 0, rc, fl);
        checkRx("cpr0x0", 6, 72'h1B5B313B3152);
        applyStimulus(2'd1, 8'h00, 255, 9, rc, fl);
        checkRx("cpr255x9", 9, 72'h1B5B3235363B313052);

        // DA with a raw request held during the transmission: it must be ignored.
        while (!reqReady) @(negedge clk);
        reqType = 2'd2;
        reqValid = 1'b1;
        @(negedge clk);
        reqType = 2'd3;
        reqByte = 8'h41;
        repeat (1100) @(negedge clk);
        reqValid = 1'b0;
        n = 0;
        while (!reqReady && n < 2000) begin @(negedge clk); n++; end
        checkOutput("daReady", int'(reqReady), 1);
        checkRx("da", 7, 72'h1B5B3F313B3063);
        applyStimulus(2'd3, 8'h41, 0, 0, rc, fl);
        checkOutput("rawReadyCycle", rc, FrameBits * Div + 2);
        checkRx("raw41", 1, 72'h41);

`ifdef UART_TX_EVEN_PARITY_EN
        applyStimulus(2'd3, 8'h31, 0, 0, rc, fl);
        checkOutput("raw31ReadyCycle", rc, 178);
        checkOutput("raw31Parity", int'(lastParity), 1);
        checkRx("raw31", 1, 72'h31);
        applyStimulus(2'd3, 8'h33, 0, 0, rc, fl);
        checkOutput("raw33Parity", int'(lastParity), 0);
        checkRx("raw33", 1, 72'h33);
`endif

        // Reset during the 5th data bit of the second byte.
        while (!reqReady) @(negedge clk);
        reqType = 2'd0;
        reqValid = 1'b1;
        @(negedge clk);
        reqValid = 1'b0;
        repeat (250) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midResetTxD", int'(TxD), 1);
        checkOutput("midResetBusy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        edges = 0;
        prevTx = TxD;
        repeat (300) begin
            @(negedge clk);
            if (TxD != prevTx) edges++;
            prevTx = TxD;
        end
        checkOutput("postResetEdges", edges, 0);
        waitDecoderIdle();
        rxQ.delete();
        applyStimulus(2'd0, 8'h00, 0, 0, rc, fl);
        checkRx("dsrAfterReset", 4, 72'h1B5B306E);

        // Randomized traffic, including strobes while busy and back-to-back accepts.
        waitDecoderIdle();
        rxQ.delete();
        expByteQ.delete();
        repeat (20000) begin
            @(negedge clk);
            reqValid  = ($urandom_range(0, 3) == 0);
            reqType   = 2'($urandom_range(0, 3));
            reqByte   = 8'($urandom_range(0, 255));
            cursorRow = CoordW'($urandom_range(0, 255));
            cursorCol = CoordW'($urandom_range(0, 255));
        end
        reqValid = 1'b0;
        n = 0;
        while (!reqReady && n < 5000) begin @(negedge clk); n++; end
        checkOutput("randomDrainReady", int'(reqReady), 1);
        waitDecoderIdle();
        checkOutput("randomByteCount", rxQ.size(), expByteQ.size());
        for (int i = 0; i < rxQ.size() && i < expByteQ.size(); i++) begin
            checkOutput($sformatf("randomByte%0d", i), int'(rxQ[i]), int'(expByteQ[i]));
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
